branch_pred_ctrl: RTL and testbench

//  Parametrised branch prediction/resolution controller for the 5-stage RV32 pipeline; successor to the

---
 rtl/bpu_pkg.sv | 46 ++++
 rtl/branch_cond.sv | 26 ++
 rtl/branch_pred_ctrl.sv | 108 ++++++++++
 tb/tb_branch_pred_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: branch funct3 codes,
// 2-bit counter states, predictor modes and the BHT index/counter helpers.
package bpu_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int IDX_PC_W = 64;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum int {
        PM_STATIC  = 0,
        PM_BIMODAL = 1,
        PM_GSHARE  = 2
    } pred_mode_e;

    // Word index of the PC, optionally hashed with history, masked to iw bits.
    function automatic logic [IDX_PC_W-1:0] bht_idx(input logic [IDX_PC_W-1:0] pc,
                                                    input logic [IDX_PC_W-1:0] ghr,
                                                    input int iw);
        logic [IDX_PC_W-1:0] mask;
        mask = (IDX_PC_W'(1) << iw) - IDX_PC_W'(1);
        return ((pc >> 2) ^ ghr) & mask;
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken && c != ST)
            n = c + 2'd1;
        else if (!taken && c != SNT)
            n = c - 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from funct3 and the ALU flags of rs1-rs2.
module branch_cond
    import bpu_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [3:0] nzcv_i,
    output logic       cond_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv_i;

    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_o = z;
            F3_BNE:  cond_o = ~z;
            F3_BLT:  cond_o = n ^ v;
            F3_BGE:  cond_o = ~(n ^ v);
            F3_BLTU: cond_o = ~c;
            F3_BGEU: cond_o = c;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predict (Fetch) / resolve (Execute) controller with a 2-bit BHT.
// Define BPU_PERF_EN to instantiate the resolved-branch and redirect counters.
module branch_pred_ctrl
    import bpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PRED_MODE = 1,
    parameter int GHR_W     = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] f_pc_i,
    input  logic            f_is_branch_i,
    input  logic            f_is_jal_i,
    input  logic [XLEN-1:0] f_imm_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            e_valid_i,
    input  logic            e_branch_i,
    input  logic            e_jal_i,
    input  logic            e_jalr_i,
    input  logic [2:0]      e_funct3_i,
    input  logic [3:0]      e_nzcv_i,
    input  logic [XLEN-1:0] e_pc_i,
    input  logic            e_pred_i,
    input  logic [XLEN-1:0] e_target_i,
    input  logic [XLEN-1:0] e_pc_plus4_i,
    output logic            e_taken_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_d_o,
    output logic            flush_e_o,
    output logic [31:0]     perf_br_o,
    output logic [31:0]     perf_mis_o
);

    localparam int IW      = $clog2(BHT_DEPTH);
    localparam bit UPD_EN  = (PRED_MODE != PM_STATIC);
    localparam bit USE_GHR = (PRED_MODE == PM_GSHARE);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [IW-1:0]    idx_f, idx_e;
    logic [IDX_PC_W-1:0] ghr_ext;
    logic [1:0]       ctr_d;
    logic             cond, upd;

    branch_cond u_cond (
        .funct3_i (e_funct3_i),
        .nzcv_i   (e_nzcv_i),
        .cond_o   (cond)
    );

    assign ghr_ext = USE_GHR ? IDX_PC_W'(ghr_q) : '0;
    assign idx_f   = IW'(bht_idx(IDX_PC_W'(f_pc_i), ghr_ext, IW));
    assign idx_e   = IW'(bht_idx(IDX_PC_W'(e_pc_i), ghr_ext, IW));

    assign pred_taken_o  = f_is_jal_i | (f_is_branch_i & UPD_EN & bht_q[idx_f][1]);
    assign pred_target_o = f_pc_i + f_imm_i;

    assign e_taken_o     = e_valid_i & (e_jal_i | e_jalr_i | (e_branch_i & cond));
    // JAL is always predicted taken in Fetch, so only JALR and branches can miss.
    assign redirect_o    = ~rst & e_valid_i & (e_jalr_i | (e_branch_i & (cond != e_pred_i)));
    assign redirect_pc_o = e_taken_o ? e_target_i : e_pc_plus4_i;
    assign flush_d_o     = redirect_o;
    assign flush_e_o     = redirect_o;

    assign upd   = e_valid_i & e_branch_i & UPD_EN;
    assign ctr_d = ctr_next(bht_q[idx_e], cond);
    assign ghr_d = GHR_W'({ghr_q, cond});

    // Fetch reads bht_q directly, so a same-cycle update is seen one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht_q[i] <= WNT;
            ghr_q <= '0;
        end else if (upd) begin
            bht_q[idx_e] <= ctr_d;
            if (USE_GHR)
                ghr_q <= ghr_d;
        end
    end

`ifdef BPU_PERF_EN
    logic [31:0] perf_br_q, perf_mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (e_valid_i & e_branch_i)
                perf_br_q <= perf_br_q + 32'd1;
            if (redirect_o)
                perf_mis_q <= perf_mis_q + 32'd1;
        end
    end

    assign perf_br_o  = perf_br_q;
    assign perf_mis_o = perf_mis_q;
`else
    assign perf_br_o  = '0;
    assign perf_mis_o = '0;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench: static, bimodal and gshare (GHR_W=2) instances share stimulus;
// a behavioural predictor model queues expected outputs, a negedge monitor checks.
module tb_branch_pred_ctrl;

    localparam int NDUT  = 3;
    localparam int DEPTH = 64;
    localparam int GW    = 2;
    localparam int MODES [NDUT] = '{0, 1, 2};
`ifdef BPU_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] f_pc, f_imm, e_pc, e_target, e_pc4;
    logic        f_is_branch, f_is_jal;
    logic        e_valid, e_branch, e_jal, e_jalr, e_pred;
    logic [2:0]  e_funct3;
    logic [3:0]  e_nzcv;

    logic [NDUT-1:0] pred_taken, e_taken, redirect, flush_d, flush_e;
    logic [31:0]     pred_target [NDUT];
    logic [31:0]     redirect_pc [NDUT];
    logic [31:0]     perf_br     [NDUT];
    logic [31:0]     perf_mis    [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        branch_pred_ctrl #(
            .XLEN(32), .BHT_DEPTH(DEPTH), .PRED_MODE(MODES[g]), .GHR_W(GW)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .f_pc_i        (f_pc),
            .f_is_branch_i (f_is_branch),
            .f_is_jal_i    (f_is_jal),
            .f_imm_i       (f_imm),
            .pred_taken_o  (pred_taken[g]),
            .pred_target_o (pred_target[g]),
            .e_valid_i     (e_valid),
            .e_branch_i    (e_branch),
            .e_jal_i       (e_jal),
            .e_jalr_i      (e_jalr),
            .e_funct3_i    (e_funct3),
            .e_nzcv_i      (e_nzcv),
            .e_pc_i        (e_pc),
            .e_pred_i      (e_pred),
            .e_target_i    (e_target),
            .e_pc_plus4_i  (e_pc4),
            .e_taken_o     (e_taken[g]),
            .redirect_o    (redirect[g]),
            .redirect_pc_o (redirect_pc[g]),
            .flush_d_o     (flush_d[g]),
            .flush_e_o     (flush_e[g]),
            .perf_br_o     (perf_br[g]),
            .perf_mis_o    (perf_mis[g])
        );
    end

    typedef struct packed {
        logic [NDUT-1:0]       pred;
        logic [NDUT-1:0]       redir;
        logic                  taken;
        logic [31:0]           target;
        logic [31:0]           rpc;
        logic [31:0]           pbr;
        logic [NDUT-1:0][31:0] pmis;
        logic                  late;
    } exp_t;

    exp_t expq [$];
    int checks = 0;
    int failures = 0;
    int late_mis = 0;

    // Behavioural predictor state: counter values 0..3 and history as an integer.
    int          bht [NDUT][DEPTH];
    int          ghr [NDUT];
    int unsigned m_br;
    int unsigned m_mis [NDUT];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    function automatic int model_idx(input int d, input logic [31:0] pc);
        int i;
        i = int'((pc / 4) % DEPTH);
        if (MODES[d] == 2)
            i = i ^ ghr[d];
        return i;
    endfunction

    function automatic bit model_cond(input logic [2:0] f3, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n != v;
            3'd5: return n == v;
            3'd6: return !c;
            3'd7: return c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < DEPTH; i++) bht[d][i] = 1;
            ghr[d] = 0;
            m_mis[d] = 0;
        end
        m_br = 0;
    endtask

    // Queue the expectation for the current inputs, advance the model, clock once.
    task automatic step(input bit late = 1'b0);
        exp_t e;
        bit   cnd;
        int   i;
        cnd      = model_cond(e_funct3, e_nzcv);
        e        = '0;
        e.target = f_pc + f_imm;
        e.taken  = e_valid && (e_jal || e_jalr || (e_branch && cnd));
        e.rpc    = e.taken ? e_target : e_pc4;
        e.pbr    = m_br;
        e.late   = late;
        for (int d = 0; d < NDUT; d++) begin
            e.pred[d]  = f_is_jal || (f_is_branch && MODES[d] != 0 && bht[d][model_idx(d, f_pc)] >= 2);
            e.redir[d] = !rst && e_valid && (e_jalr || (e_branch && (cnd != e_pred)));
            e.pmis[d]  = m_mis[d];
        end
        expq.push_back(e);
        if (rst) begin
            model_reset();
        end else begin
            if (e_valid && e_branch) m_br++;
            for (int d = 0; d < NDUT; d++) begin
                if (e.redir[d]) m_mis[d]++;
                if (e_valid && e_branch && MODES[d] != 0) begin
                    i = model_idx(d, e_pc);
                    bht[d][i] = cnd ? ((bht[d][i] == 3) ? 3 : bht[d][i] + 1)
                                    : ((bht[d][i] == 0) ? 0 : bht[d][i] - 1);
                    if (MODES[d] == 2) ghr[d] = ((ghr[d] * 2) + int'(cnd)) % (1 << GW);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            for (int d = 0; d < NDUT; d++) begin
                chk("pred_taken",    d, 32'(pred_taken[d]), 32'(e.pred[d]));
                chk("pred_target",   d, pred_target[d],     e.target);
                chk("e_taken",       d, 32'(e_taken[d]),    32'(e.taken));
                chk("redirect",      d, 32'(redirect[d]),   32'(e.redir[d]));
                chk("redirect_pc",   d, redirect_pc[d],     e.rpc);
                chk("flush_d",       d, 32'(flush_d[d]),    32'(e.redir[d]));
                chk("flush_e",       d, 32'(flush_e[d]),    32'(e.redir[d]));
                chk("perf_br",       d, perf_br[d],         PERF ? e.pbr : 32'd0);
                chk("perf_mis",      d, perf_mis[d],        PERF ? e.pmis[d] : 32'd0);
            end
            if (e.late && redirect[2]) late_mis++;
        end
    end

    task automatic idle();
        f_pc = 32'h0; f_imm = 32'h0; f_is_branch = 0; f_is_jal = 0;
        e_valid = 0; e_branch = 0; e_jal = 0; e_jalr = 0; e_pred = 0;
        e_funct3 = 3'd0; e_nzcv = 4'd0; e_pc = 32'h0; e_target = 32'h0; e_pc4 = 32'h4;
    endtask

    task automatic set_e(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [3:0] fl, input logic [31:0] pc, input logic pred);
        e_valid = 1; e_branch = br; e_jal = jal; e_jalr = jalr; e_funct3 = f3; e_nzcv = fl;
        e_pc = pc; e_pred = pred; e_target = pc + 32'h100; e_pc4 = pc + 32'h4;
    endtask

    initial begin
        rst = 1;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        // Reset held: redirect suppressed even with a valid JALR in Execute.
        f_is_branch = 1; f_pc = 32'h0000_1234 & ~32'h3;
        set_e(0, 0, 1, 3'd0, 4'd0, 32'h200, 0);
        step();
        step();
        rst = 0;
        idle();
        for (int k = 0; k < 4; k++) begin
            f_is_branch = 1; f_pc = 32'($urandom) & ~32'h3; f_imm = 32'($urandom);
            step();
        end
        // Train PC 0x40 taken twice, then fetch it.
        idle();
        set_e(1, 0, 0, 3'd0, 4'b0100, 32'h40, 0);
        step();
        step();
        idle();
        f_is_branch = 1; f_pc = 32'h40; f_imm = 32'h20;
        step();
        // BLT with N=1 V=0, predicted not-taken.
        idle();
        set_e(1, 0, 0, 3'd4, 4'b1000, 32'h60, 0);
        step();
        // Saturate 0x80 at ST, then BGEU not-taken predicted taken.
        for (int k = 0; k < 4; k++) begin
            set_e(1, 0, 0, 3'd7, 4'b0010, 32'h80, k >= 2);
            step();
        end
        set_e(1, 0, 0, 3'd7, 4'b0000, 32'h80, 1);
        step();
        idle();
        f_is_branch = 1; f_pc = 32'h80;
        step();
        // JALR always redirects; JAL never; invalid Execute does nothing.
        set_e(0, 0, 1, 3'd0, 4'd0, 32'hA0, 0); step();
        set_e(0, 0, 1, 3'd0, 4'd0, 32'hA4, 1); step();
        set_e(0, 1, 0, 3'd0, 4'd0, 32'hA8, 1); step();
        set_e(1, 0, 0, 3'd0, 4'b0100, 32'h80, 0); e_valid = 0; step();
        set_e(1, 0, 0, 3'd0, 4'b0100, 32'h80, 0); e_valid = 0; f_is_branch = 1; f_pc = 32'h80; step();
        // Fetch and Execute on the same index: Fetch sees the pre-update counter.
        for (int k = 0; k < 3; k++) begin
            idle();
            set_e(1, 0, 0, 3'd1, 4'b0000, 32'hC0, 0);
            f_is_branch = 1; f_pc = 32'hC0;
            step();
        end
        // Alternating T/N on one PC from a clean history.
        idle(); rst = 1; step(); rst = 0;
        for (int k = 0; k < 32; k++) begin
            idle();
            set_e(1, 0, 0, 3'd0, (k % 2 == 0) ? 4'b0100 : 4'b0000, 32'h140,
                  bht[2][model_idx(2, 32'h140)] >= 2);
            f_is_branch = 1; f_pc = 32'h140;
            step(k >= 8);
        end
        // Random traffic over a small aliasing PC set with occasional reset.
        for (int k = 0; k < 500; k++) begin
            int kind;
            rst         = ($urandom_range(0, 49) == 0);
            f_pc        = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8);
            f_imm       = 32'($urandom);
            f_is_branch = 1'($urandom);
            f_is_jal    = ($urandom_range(0, 7) == 0);
            kind        = $urandom_range(0, 5);
            set_e(kind <= 2, kind == 3, kind == 4, 3'($urandom), 4'($urandom),
                  (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8), 1'($urandom));
            e_target = 32'($urandom) & ~32'h1;
            e_valid  = ($urandom_range(0, 9) != 0);
            step();
        end
        rst = 0;
        idle();
        @(negedge clk);
        #1;
        chk("gshare_late_mispredicts", 2, 32'(late_mis), 32'd0);
        chk("scoreboard_drained", 0, 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
